// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request, operand-read and register-file drive signals shared by
// the execute/memory stages, decode and the write-back arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              AluValid;
  logic              AluReady;
  logic [ADDR_W-1:0] AluDest;
  logic [DATA_W-1:0] AluData;
  logic              MemValid;
  logic              MemReady;
  logic [ADDR_W-1:0] MemDest;
  logic [DATA_W-1:0] MemData;
  logic              RdReq;
  logic [ADDR_W-1:0] RdSelA;
  logic [ADDR_W-1:0] RdSelB;
  logic              Stall;
  logic              RfWriteEnable;
  logic [ADDR_W-1:0] RfSelectInput;
  logic [DATA_W-1:0] RfIn;
  logic [ADDR_W-1:0] RfSelectA;
  logic [ADDR_W-1:0] RfSelectB;
  logic [CNT_W-1:0]  WriteCount;

  modport master (
    output AluValid, AluDest, AluData, MemValid, MemDest, MemData,
           RdReq, RdSelA, RdSelB,
    input  AluReady, MemReady, Stall, RfWriteEnable, RfSelectInput, RfIn,
           RfSelectA, RfSelectB, WriteCount
  );

  modport slave (
    input  AluValid, AluDest, AluData, MemValid, MemDest, MemData,
           RdReq, RdSelA, RdSelB,
    output AluReady, MemReady, Stall, RfWriteEnable, RfSelectInput, RfIn,
           RfSelectA, RfSelectB, WriteCount
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// memory write-back paths, with read-after-write stall detection for decode.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic Clock,
  input  logic Reset,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e            last_grant;
  logic              alu_grant;
  logic              alu_fire;
  logic              mem_fire;
  logic              match_a;
  logic              match_b;
  logic              stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  wr_count;

  // Grant and hazard decode; nothing is accepted or stalled while in reset.
  always_comb begin
    alu_grant = 1'b0;
    alu_fire  = 1'b0;
    mem_fire  = 1'b0;
    match_a   = 1'b0;
    match_b   = 1'b0;
    stall     = 1'b0;

    alu_grant = bus.AluValid & (~bus.MemValid | (last_grant == GRANT_MEM));
    alu_fire  = Reset & alu_grant;
    mem_fire  = Reset & bus.MemValid & ~alu_grant;

    match_a = (bus.AluValid && (bus.AluDest == bus.RdSelA)) ||
              (bus.MemValid && (bus.MemDest == bus.RdSelA)) ||
              (wr_en        && (wr_sel      == bus.RdSelA));
    match_b = (bus.AluValid && (bus.AluDest == bus.RdSelB)) ||
              (bus.MemValid && (bus.MemDest == bus.RdSelB)) ||
              (wr_en        && (wr_sel      == bus.RdSelB));
    stall   = Reset & bus.RdReq & (match_a | match_b);
  end

  // Accepted request becomes the register-file write one cycle later.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_grant <= GRANT_MEM;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      wr_data    <= '0;
      wr_count   <= '0;
    end else begin
      wr_en <= alu_fire | mem_fire;
      if (alu_fire) begin
        last_grant <= GRANT_ALU;
        wr_sel     <= bus.AluDest;
        wr_data    <= bus.AluData;
      end else if (mem_fire) begin
        last_grant <= GRANT_MEM;
        wr_sel     <= bus.MemDest;
        wr_data    <= bus.MemData;
      end
      if (wr_en) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  assign bus.AluReady      = alu_fire;
  assign bus.MemReady      = mem_fire;
  assign bus.Stall         = stall;
  assign bus.RfWriteEnable = wr_en;
  assign bus.RfSelectInput = wr_sel;
  assign bus.RfIn          = wr_data;
  assign bus.RfSelectA     = bus.RdSelA;
  assign bus.RfSelectB     = bus.RdSelB;
  assign bus.WriteCount    = wr_count;

endmodule
